// File: rtl/writeback_arbiter.sv
// Merges the load and ALU result streams onto the single register-file write port.
// Loads always win; ALU results wait in a small FIFO whose entries can be killed by younger loads.
module writeback_arbiter #(
  parameter int ALU_DEPTH = 4,
  parameter int CNT_W     = $clog2(ALU_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             load_valid,
  input  logic [4:0]       load_rd,
  input  logic [31:0]      load_data,
  output logic [4:0]       register_write,
  output logic [31:0]      write_data,
  output logic             register_write_enable,
  input  logic [4:0]       query_rs1,
  input  logic [4:0]       query_rs2,
  output logic             hazard_rs1,
  output logic             hazard_rs2,
  output logic [CNT_W-1:0] pending_count
);

  localparam int PTR_W = (ALU_DEPTH > 1) ? $clog2(ALU_DEPTH) : 1;

  // Handshake: an ALU result transfers on a rising edge where alu_valid && alu_ready;
  // alu_valid may be held, and alu_ready depends only on FIFO occupancy and rst_n.
  logic [4:0]           rd_q   [ALU_DEPTH];
  logic [31:0]          data_q [ALU_DEPTH];
  logic [ALU_DEPTH-1:0] live_q, live_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [4:0]           wb_rd_q, wb_rd_d;
  logic [31:0]          wb_data_q, wb_data_d;
  logic                 wb_en_q, wb_en_d;
  logic                 full, empty, push, pop;

  assign full      = (count_q == CNT_W'(ALU_DEPTH));
  assign empty     = (count_q == '0);
  assign alu_ready = !full && rst_n;
  assign push      = alu_valid && alu_ready;
  assign pop       = !load_valid && !empty;

  always_comb begin
    live_d    = live_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    wb_en_d   = 1'b0;
    if (load_valid) begin
      wb_rd_d   = load_rd;
      wb_data_d = load_data;
      wb_en_d   = (load_rd != 5'd0);
      // The load is younger than every queued entry, so older writes to its rd must die.
      for (int i = 0; i < ALU_DEPTH; i++) begin
        if (load_rd != 5'd0 && rd_q[i] == load_rd) live_d[i] = 1'b0;
      end
    end else if (pop) begin
      wb_rd_d           = rd_q[rd_ptr_q];
      wb_data_d         = data_q[rd_ptr_q];
      wb_en_d           = live_q[rd_ptr_q] && (rd_q[rd_ptr_q] != 5'd0);
      live_d[rd_ptr_q]  = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    // Push after the kill loop: an entry entering alongside a load is younger and survives.
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      live_q    <= live_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      wb_en_q   <= wb_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= alu_rd;
      data_q[wr_ptr_q] <= alu_data;
    end
  end

  // Live bits are cleared on pop, so a live bit alone implies an occupied slot.
  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    for (int i = 0; i < ALU_DEPTH; i++) begin
      if (live_q[i] && query_rs1 != 5'd0 && rd_q[i] == query_rs1) hazard_rs1 = 1'b1;
      if (live_q[i] && query_rs2 != 5'd0 && rd_q[i] == query_rs2) hazard_rs2 = 1'b1;
    end
  end

  assign register_write        = wb_rd_q;
  assign write_data            = wb_data_q;
  assign register_write_enable = wb_en_q;
  assign pending_count         = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected enabled writes go into a queue that a
// negedge monitor drains; occupancy, ready and hazard flags are checked inline.
module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, load_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd, load_rd, register_write, query_rs1, query_rs2;
  logic [31:0] alu_data, load_data, write_data;
  logic        register_write_enable, hazard_rs1, hazard_rs2;
  logic [2:0]  pending_count;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  writeback_arbiter #(.ALU_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data),
    .register_write(register_write), .write_data(write_data),
    .register_write_enable(register_write_enable),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .hazard_rs1(hazard_rs1), .hazard_rs2(hazard_rs2),
    .pending_count(pending_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard monitor: every enabled write must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (register_write_enable === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                 register_write, write_data);
      end else begin
        e = exp_q.pop_front();
        if ({register_write, write_data} !== e) begin
          failures++;
          $display("FAIL write_order: got rd=%0d data=%h, expected rd=%0d data=%h",
                   register_write, write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    alu_valid  = av;  alu_rd  = ard; alu_data  = ad;
    load_valid = lv;  load_rd = lrd; load_data = ld;
    @(posedge clk);
    #1;
    alu_valid  = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    load_valid = 1'b0; load_rd = '0; load_data = '0;
    query_rs1 = 5'd5; query_rs2 = 5'd6;

    // Reset state
    idle(2);
    chk("ready_in_reset", 32'(alu_ready), 32'd0);
    chk("reset_en", 32'(register_write_enable), 32'd0);
    chk("reset_rd", 32'(register_write), 32'd0);
    chk("reset_data", write_data, 32'd0);
    chk("reset_count", 32'(pending_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", 32'(alu_ready), 32'd1);

    // Single ALU result, two-cycle latency and transient hazard
    expect_wr(5'd5, 32'hDEADBEEF);
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("t1_count_after_push", 32'(pending_count), 32'd1);
    chk("t1_hazard_rs1", 32'(hazard_rs1), 32'd1);
    chk("t1_hazard_rs2", 32'(hazard_rs2), 32'd0);
    chk("t1_en_not_yet", 32'(register_write_enable), 32'd0);
    idle(1);
    chk("t1_en_after_pop", 32'(register_write_enable), 32'd1);
    chk("t1_hazard_cleared", 32'(hazard_rs1), 32'd0);
    chk("t1_count_empty", 32'(pending_count), 32'd0);

    // Fill FIFO under four loads, then drain in order
    query_rs1 = 5'd20;
    for (int i = 0; i < 4; i++) begin
      expect_wr(5'(10 + i), 32'h100 + 32'(i));
      cyc(1'b1, 5'(20 + i), 32'h200 + 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
    end
    chk("t2_count_full", 32'(pending_count), 32'd4);
    chk("t2_ready_full", 32'(alu_ready), 32'd0);
    chk("t2_hazard_queued", 32'(hazard_rs1), 32'd1);
    for (int i = 0; i < 4; i++) expect_wr(5'(20 + i), 32'h200 + 32'(i));
    idle(4);
    chk("t2_count_drained", 32'(pending_count), 32'd0);

    // WAW kill by a younger load
    query_rs1 = 5'd7;
    cyc(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 32'd0);
    chk("t3_hazard_before_load", 32'(hazard_rs1), 32'd1);
    expect_wr(5'd7, 32'h2);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2);
    chk("t3_hazard_killed", 32'(hazard_rs1), 32'd0);
    chk("t3_count_killed_kept", 32'(pending_count), 32'd1);
    chk("t3_load_data", write_data, 32'h2);
    idle(1);
    chk("t3_killed_pop_en", 32'(register_write_enable), 32'd0);
    chk("t3_killed_pop_data", write_data, 32'h1);
    chk("t3_count_after_pop", 32'(pending_count), 32'd0);

    // Writes to x0 never enable
    query_rs1 = 5'd0;
    cyc(1'b1, 5'd0, 32'hAA, 1'b0, 5'd0, 32'd0);
    chk("t4_hazard_x0", 32'(hazard_rs1), 32'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBB);
    chk("t4_load_x0_en", 32'(register_write_enable), 32'd0);
    chk("t4_load_x0_data", write_data, 32'hBB);
    idle(1);
    chk("t4_alu_x0_en", 32'(register_write_enable), 32'd0);
    chk("t4_alu_x0_data", write_data, 32'hAA);

    // Simultaneous push/pop at count 2 and pointer wrap
    expect_wr(5'd2, 32'h601);
    cyc(1'b1, 5'd1, 32'h501, 1'b1, 5'd2, 32'h601);
    expect_wr(5'd4, 32'h602);
    cyc(1'b1, 5'd3, 32'h502, 1'b1, 5'd4, 32'h602);
    chk("t5_count_two", 32'(pending_count), 32'd2);
    expect_wr(5'd1, 32'h501);
    expect_wr(5'd3, 32'h502);
    expect_wr(5'd5, 32'h503);
    cyc(1'b1, 5'd5, 32'h503, 1'b0, 5'd0, 32'd0);
    chk("t5_count_push_pop", 32'(pending_count), 32'd2);
    for (int k = 0; k < 10; k++) begin
      expect_wr(5'(6 + k), 32'h900 + 32'(k));
      cyc(1'b1, 5'(6 + k), 32'h900 + 32'(k), 1'b0, 5'd0, 32'd0);
    end
    chk("t5_count_after_wrap", 32'(pending_count), 32'd2);
    idle(2);
    chk("t5_count_drained", 32'(pending_count), 32'd0);

    // Reset with three queued entries discards them
    query_rs1 = 5'd16;
    for (int i = 0; i < 3; i++) begin
      expect_wr(5'(17 + 2 * i), 32'h800 + 32'(i));
      cyc(1'b1, 5'(16 + 2 * i), 32'h700 + 32'(i), 1'b1, 5'(17 + 2 * i), 32'h800 + 32'(i));
    end
    chk("t6_count_three", 32'(pending_count), 32'd3);
    chk("t6_hazard_queued", 32'(hazard_rs1), 32'd1);
    rst_n = 1'b0;
    idle(1);
    chk("t6_reset_en", 32'(register_write_enable), 32'd0);
    chk("t6_reset_count", 32'(pending_count), 32'd0);
    chk("t6_reset_hazard", 32'(hazard_rs1), 32'd0);
    chk("t6_reset_ready", 32'(alu_ready), 32'd0);
    rst_n = 1'b1;
    idle(4);
    chk("t6_count_stays_zero", 32'(pending_count), 32'd0);

    // Final report
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Merges the ALU result stream and the load-unit result stream into the single write port of the integer register file (register_write / write_data / register_write_enable).
- Load results are never stalled and always have priority. ALU results queue in a small FIFO and drain on cycles with no load.
- Preserves write-after-write order per destination register.
- Exports per-register pending-write hazard flags for the decode stage's stall logic.

Parameters:
- ALU_DEPTH, 4, ALU result FIFO entries (power of two, >=2).
- CNT_W, $clog2(ALU_DEPTH+1), width of pending_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  FIFO can accept (combinational: !full && rst_n).
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- load_valid  in  1  load result present; always accepted, no ready.
- load_rd  in  5  load destination register.
- load_data  in  32  load result.
- register_write  out  5  registered destination to the register file.
- write_data  out  32  registered write data.
- register_write_enable  out  1  registered write strobe.
- query_rs1  in  5  decode-stage source 1.
- query_rs2  in  5  decode-stage source 2.
- hazard_rs1  out  1  live queued write to query_rs1 (combinational).
- hazard_rs2  out  1  same for query_rs2.
- pending_count  out  CNT_W  occupied FIFO entries, killed entries included.

Behaviour:
- Reset:
  - Synchronous, when rst_n=0 at a rising edge.
  - Clears register_write=0, write_data=0, register_write_enable=0, FIFO pointers/count=0, all entry live bits=0.
  - alu_ready=0 while rst_n=0.
  - Reset mid-drain discards all queued entries; no write is issued for them.
- Accept:
  - ALU handshake fires when alu_valid && alu_ready. The entry {rd, data, live=1} is pushed at that edge.
  - A load is taken every cycle load_valid=1.
- Output select, each edge:
  - If load_valid: output regs <= {load_rd, load_data}; no pop.
  - Else if FIFO non-empty: pop head; output regs <= {head.rd, head.data}.
  - Else: enable <= 0. register_write and write_data hold their previous values.
- Write enable:
  - register_write_enable is asserted only when the selected entry is live and its rd != 0.
  - Entries with rd=0, and killed entries, still pop but issue enable=0.
- Latency:
  - Load: visible on outputs 1 cycle after acceptance.
  - ALU into an empty FIFO with no load: 2 cycles (push edge, then pop edge).
- WAW kill:
  - On a load edge, every live FIFO entry with rd == load_rd (rd != 0) gets live <= 0 at that edge. The load is younger and must win.
  - An ALU entry pushed on the same edge as the load is younger than the load and is not killed.
- Simultaneous push and pop:
  - Allowed in the same cycle; count is unchanged.
  - A push when full is impossible, because alu_ready=0.
  - Pop and push on an empty FIFO in the same cycle are not combined; there is no bypass, and the new entry pops next cycle at the earliest.
- Pointers: wrap modulo ALU_DEPTH. Full = (count == ALU_DEPTH); empty = (count == 0).
- Hazard flags:
  - hazard_rsN=1 iff query_rsN != 0 and some occupied entry is live with rd == query_rsN.
  - The output register is not included; the register file absorbs that write in the same cycle.
- Starvation: back-to-back loads may hold the FIFO indefinitely. This is acceptable; upstream sees alu_ready=0.

Test Plan:
- Reset then ALU push {rd=5, 0xDEADBEEF} at edge 1, no loads -> enable=1, register_write=5, write_data=0xDEADBEEF after edge 2; hazard_rs1=1 for query 5 only between edges 1 and 2.
- Fill 4 ALU entries while load_valid=1 for 4 cycles -> alu_ready=0 and pending_count=4; loads appear on outputs each cycle; ALU entries then drain in order over the next 4 cycles.
- ALU push rd=7 data 0x1, next cycle load rd=7 data 0x2 -> output shows 0x2 with enable=1; the later pop of the rd=7 entry shows enable=0; hazard on 7 clears at the load edge.
- ALU push rd=0 and load rd=0 -> enable stays 0 on both pops/writes; hazard_rs1 is 0 for query 0.
- Simultaneous push and pop at count=2 -> count stays 2; wrap past index 3 keeps FIFO order across 10 sequential pushes.
- rst_n=0 with 3 entries queued -> after the edge, enable=0, pending_count=0, no queued write ever emitted, hazards=0.
